// File: rtl/fft_frame_seq.sv
// fft_frame_seq: streams one frame of N samples from the sample RAM into the
// FFT core input, then waits for the FFT output frame to finish.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   buf_ready         pulse from RAM writer: a full frame is ready
//   rd_en/rd_addr     RAM read port (this block is its only owner)
//   rd_data           RAM read data, valid one cycle after rd_en
//   fft_t*            AXI-stream style sample output (valid/ready/last/data)
//   fft_out_tvalid/   FFT output stream observation, only the last beat
//   fft_out_tlast     matters
//   busy              high outside IDLE
//   frame_done        one-cycle pulse when the FFT output frame has ended
//   err_overrun       registered pulse: buf_ready arrived while busy
//   err_timeout       registered pulse: FFT output never ended in time
//   overrun_cnt       saturating overrun count (FFT_SEQ_OVERRUN_CNT_EN only)
//
// Build option: define FFT_SEQ_OVERRUN_CNT_EN to add the overrun_cnt port.
module fft_frame_seq #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 16,
  parameter int N       = 4096,
  parameter int TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              buf_ready,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] fft_tdata,
  output logic              fft_tvalid,
  input  logic              fft_tready,
  output logic              fft_tlast,
  input  logic              fft_out_tvalid,
  input  logic              fft_out_tlast,
  output logic              busy,
  output logic              frame_done,
  output logic              err_overrun,
  output logic              err_timeout
`ifdef FFT_SEQ_OVERRUN_CNT_EN
  ,
  output logic [7:0]        overrun_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WAIT_OUT, S_DONE} state_t;

  localparam logic [ADDR_W:0] N_L     = (ADDR_W+1)'(N);
  localparam logic [ADDR_W:0] LAST_L  = (ADDR_W+1)'(N-1);
  localparam logic [ADDR_W:0] IDX_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [15:0]     TO_LAST = 16'(TIMEOUT-1);

  state_t state, state_nx;

  // rd_idx: reads issued, out_idx: samples handed to the FFT. Both are one
  // bit wider than the address so they can sit at N without wrapping.
  logic [ADDR_W:0] rd_idx, out_idx;
  logic            inflight;          // rd_en was high last cycle
  logic [DATA_W-1:0] fifo_mem [2];
  logic            wr_ptr, rd_ptr;
  logic [1:0]      fifo_cnt;
  logic [15:0]     wait_cnt;
  logic            pop, issue, out_end, timeout_hit;
  logic [2:0]      occ;

  always_comb begin
    fft_tvalid = (fifo_cnt != 2'd0);
    fft_tdata  = fifo_mem[rd_ptr];
    fft_tlast  = fft_tvalid && (out_idx == LAST_L);
    pop        = fft_tvalid && fft_tready;
    // Occupancy counts reads still in flight so the 2-entry skid buffer can
    // never be overfilled; a pop this cycle frees one slot.
    occ        = {1'b0, fifo_cnt} + {2'b0, inflight};
    issue      = (state == S_READ) && (rd_idx < N_L) && (occ <= ({2'b0, pop} + 3'd1));
    rd_en      = issue;
    rd_addr    = (rd_idx == N_L) ? LAST_L[ADDR_W-1:0] : rd_idx[ADDR_W-1:0];
    busy       = (state != S_IDLE);
    frame_done = (state == S_DONE);
    out_end    = fft_out_tvalid && fft_out_tlast;
    timeout_hit = (state == S_WAIT_OUT) && !out_end && (wait_cnt == TO_LAST);
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:     if (buf_ready) state_nx = S_READ;
      S_READ:     if (pop && fft_tlast) state_nx = S_WAIT_OUT;
      S_WAIT_OUT: begin
        if (out_end)          state_nx = S_DONE;
        else if (timeout_hit) state_nx = S_IDLE;
      end
      S_DONE:     state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      rd_idx      <= '0;
      out_idx     <= '0;
      inflight    <= 1'b0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_cnt    <= 2'd0;
      wait_cnt    <= 16'd0;
      err_overrun <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nx;
      // A new frame cannot start while one is in progress, DONE included.
      err_overrun <= buf_ready && (state != S_IDLE);
      err_timeout <= timeout_hit;
      inflight    <= issue;
      if (state == S_IDLE) begin
        rd_idx  <= '0;
        out_idx <= '0;
      end else begin
        if (issue) rd_idx  <= rd_idx + IDX_ONE;
        if (pop)   out_idx <= out_idx + IDX_ONE;
      end
      if (inflight) begin
        fifo_mem[wr_ptr] <= rd_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, inflight} - {1'b0, pop};
      if ((state == S_WAIT_OUT) && !out_end && !timeout_hit)
        wait_cnt <= wait_cnt + 16'd1;
      else
        wait_cnt <= 16'd0;
    end
  end

`ifdef FFT_SEQ_OVERRUN_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      overrun_cnt <= 8'd0;
    else if (err_overrun && (overrun_cnt != 8'hFF))
      overrun_cnt <= overrun_cnt + 8'd1;
  end
`endif

endmodule

// File: doc/fft_frame_seq.md
Name: fft_frame_seq

Overview:
- Sequences one FFT frame from the sample RAM into the FFT core's input stream.
- On a buffer-ready pulse from the RAM write side, reads N samples in address order and presents them on a valid/ready/last stream, honouring backpressure.
- Waits for the FFT output frame to finish, then signals completion.
- Sits between the RAM write controller and the FFT IP; is the sole owner of the RAM read port.

Parameters:
- ADDR_W, 12, RAM address width.
- DATA_W, 16, sample width.
- N, 4096, samples per frame; 2 <= N <= 2^ADDR_W.
- TIMEOUT, 65535, max cycles allowed in WAIT_OUT before abort; 16-bit counter.

Ports:
- clk  in  1  system/FFT clock.
- rst  in  1  synchronous, active-high reset.
- buf_ready  in  1  one-cycle pulse: RAM frame written, ready to read.
- rd_en  out  1  RAM read enable.
- rd_addr  out  ADDR_W  RAM read address.
- rd_data  in  DATA_W  RAM read data, valid exactly 1 cycle after rd_en.
- fft_tdata  out  DATA_W  sample to FFT.
- fft_tvalid  out  1  sample valid.
- fft_tready  in  1  FFT accepts sample.
- fft_tlast  out  1  high with sample N-1.
- fft_out_tvalid  in  1  FFT output beat valid.
- fft_out_tlast  in  1  FFT output last beat.
- busy  out  1  high in any state except IDLE.
- frame_done  out  1  one-cycle pulse, frame complete.
- err_overrun  out  1  one-cycle pulse: buf_ready while busy.
- err_timeout  out  1  one-cycle pulse: WAIT_OUT timeout.

Behaviour:
- Single clock domain; reset is synchronous and active-high on rst, sampled at posedge clk.
- Reset values: all outputs 0, including rd_addr and fft_tdata. State IDLE; buffer empty; counters 0. Reset mid-frame aborts immediately, with no frame_done and no error pulses.
- States: IDLE -> READ -> WAIT_OUT -> DONE -> IDLE.
- IDLE: buf_ready=1 -> READ; read counter cleared.
- READ, read issue:
  - rd_en is asserted with rd_addr = k for k = 0..N-1 in order.
  - Issue rule: issue only if (buffer occupancy + reads in flight − pop this cycle) < 2.
  - Sustained one sample/cycle when fft_tready is held at 1.
  - No address issued beyond N-1; rd_addr holds at N-1 afterwards.
- READ, buffer and stream:
  - rd_data is captured into a 2-entry skid FIFO the cycle after rd_en.
  - fft_tvalid = FIFO non-empty; fft_tdata = FIFO head.
  - Once asserted, fft_tvalid and fft_tdata stay stable until the fft_tvalid & fft_tready handshake.
  - fft_tlast = 1 exactly when the head is sample N-1.
- Latency: first rd_en occurs the cycle after buf_ready is sampled; first fft_tvalid occurs 2 cycles after the first rd_en.
- READ -> WAIT_OUT: on the handshake of sample N-1.
- WAIT_OUT:
  - fft_out_tvalid & fft_out_tlast -> DONE.
  - Otherwise the cycle counter increments.
  - When the counter reaches TIMEOUT: err_timeout pulses, counter clears, -> IDLE, with no frame_done.
- DONE: frame_done=1 for one cycle -> IDLE.
- busy=0 in IDLE, 1 in all other states.
- buf_ready in any state other than IDLE:
  - Ignored; err_overrun pulses the same cycle, registered one cycle later.
  - The current frame is unaffected.
- buf_ready on the same cycle DONE returns to IDLE counts as busy, so it raises an overrun.
- fft_out_tlast while in READ or IDLE: ignored.
- Counters wrap nowhere: the read index saturates at N and is cleared only in IDLE.

Optional Feature:
- Macro: FFT_SEQ_OVERRUN_CNT_EN.
- Defined: adds output overrun_cnt, 8 bits.
  - Increments on each err_overrun pulse; saturates at 255.
  - Cleared only by rst.
- Undefined: the port is absent and no counter logic is built; all other behaviour is identical.

Test Plan:
- Nominal frame: N=16, fft_tready=1, rd_data = addr+0x100, buf_ready at cycle 0 → rd_en cycles 1-16 with rd_addr 0..15; fft_tvalid cycles 3-18 with data 0x100..0x10F; fft_tlast at cycle 18. Then fft_out_tlast at cycle 30 → frame_done at cycle 31, busy=0 at cycle 32.
- Backpressure: N=16, fft_tready toggling 1,0,0,1 repeating → all 16 samples delivered in order, none dropped or duplicated. fft_tdata is stable across every stalled cycle, and rd_en never issues with 2 samples held.
- Overrun: buf_ready pulsed during READ at sample 5 → err_overrun registered high one cycle later; the frame completes normally. With FFT_SEQ_OVERRUN_CNT_EN defined, overrun_cnt = 1, and after 300 such pulses overrun_cnt = 255.
- Timeout: TIMEOUT=20, no fft_out_tlast → err_timeout pulses 20 cycles after entering WAIT_OUT, returns to IDLE, frame_done never asserts. A following buf_ready starts a clean frame from rd_addr 0.
- Reset mid-frame: rst high at sample 7 for 1 cycle → next cycle all outputs 0 and state IDLE. A subsequent buf_ready runs a full frame from address 0 with a correct tlast position.
- Boundary: N=2, fft_tready=0 for 10 cycles after first valid → buffer holds samples 0 and 1, rd_en stays low. On release, sample 0 then sample 1 with tlast=1 on consecutive cycles.
